// File: rtl/udc_sequence_checker.sv
// Watches a 3-bit up/down counter, classifies each sampled step and locks
// onto the running direction after LOCK_COUNT consistent steps.
module udc_sequence_checker #(
    parameter int LOCK_COUNT = 3,
    parameter int ERR_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       q,
    output logic             dir,
    output logic             locked,
    output logic             step_up,
    output logic             step_down,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    localparam logic [2:0]       LOCK_RUN = 3'(LOCK_COUNT);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    logic [1:0]       state_reg, state_next;
    logic [2:0]       prev_reg, prev_next;
    logic             cand_dir_reg, cand_dir_next;
    logic [2:0]       run_reg, run_next;
    logic             dir_reg, dir_next;
    logic             locked_reg, locked_next;
    logic             step_up_reg, step_up_next;
    logic             step_down_reg, step_down_next;
    logic             err_reg, err_next;
    logic [ERR_W-1:0] err_count_reg, err_count_next;

    // Step classification against the last sampled value (mod-8 difference).
    logic [2:0] delta;
    logic       is_up, is_down, is_hold, is_err, is_step, step_dir;
    logic [2:0] run_cnt;

    assign delta    = q - prev_reg;
    assign is_up    = (delta == 3'd1);
    assign is_down  = (delta == 3'd7);
    assign is_hold  = (delta == 3'd0);
    assign is_err   = !(is_up || is_down || is_hold);
    assign is_step  = is_up || is_down;
    assign step_dir = is_down;

    always_comb begin
        state_next     = state_reg;
        prev_next      = prev_reg;
        cand_dir_next  = cand_dir_reg;
        run_next       = run_reg;
        dir_next       = dir_reg;
        locked_next    = locked_reg;
        step_up_next   = 1'b0;
        step_down_next = 1'b0;
        err_next       = 1'b0;
        err_count_next = err_count_reg;
        run_cnt        = run_reg;

        if (en) begin
            prev_next = q;
            case (state_reg)
                IDLE: begin
                    state_next = ACQUIRE;
                    run_next   = 3'd0;
                end
                ACQUIRE: begin
                    if (is_step) begin
                        if ((step_dir == cand_dir_reg) && (run_reg != 3'd0)) begin
                            run_cnt = run_reg + 3'd1;
                        end else begin
                            cand_dir_next = step_dir;
                            run_cnt       = 3'd1;
                        end
                        run_next = run_cnt;
                        if (run_cnt >= LOCK_RUN) begin
                            state_next  = LOCKED;
                            dir_next    = cand_dir_next;
                            locked_next = 1'b1;
                        end
                    end else if (is_err) begin
                        run_next = 3'd0;
                    end
                end
                LOCKED: begin
                    if (is_step && (step_dir != dir_reg)) begin
                        cand_dir_next = step_dir;
                        run_next      = 3'd1;
                        // A single-step lock threshold re-locks on the reversal itself.
                        if (LOCK_RUN == 3'd1) begin
                            dir_next = step_dir;
                        end else begin
                            state_next  = ACQUIRE;
                            locked_next = 1'b0;
                        end
                    end else if (is_err) begin
                        state_next  = ACQUIRE;
                        run_next    = 3'd0;
                        locked_next = 1'b0;
                    end
                end
                default: begin
                    state_next  = IDLE;
                    run_next    = 3'd0;
                    locked_next = 1'b0;
                end
            endcase

            if (state_reg == ACQUIRE || state_reg == LOCKED) begin
                step_up_next   = is_up;
                step_down_next = is_down;
                err_next       = is_err;
                if (is_err && (err_count_reg != ERR_MAX)) begin
                    err_count_next = err_count_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            prev_reg      <= 3'd0;
            cand_dir_reg  <= 1'b0;
            run_reg       <= 3'd0;
            dir_reg       <= 1'b0;
            locked_reg    <= 1'b0;
            step_up_reg   <= 1'b0;
            step_down_reg <= 1'b0;
            err_reg       <= 1'b0;
            err_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            prev_reg      <= prev_next;
            cand_dir_reg  <= cand_dir_next;
            run_reg       <= run_next;
            dir_reg       <= dir_next;
            locked_reg    <= locked_next;
            step_up_reg   <= step_up_next;
            step_down_reg <= step_down_next;
            err_reg       <= err_next;
            err_count_reg <= err_count_next;
        end
    end

    assign dir       = dir_reg;
    assign locked    = locked_reg;
    assign step_up   = step_up_reg;
    assign step_down = step_down_reg;
    assign err       = err_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_udc_sequence_checker.sv
// Directed scenarios plus randomized traffic for udc_sequence_checker, checked
// against a streak-based reference model of the direction detector.
module tb_udc_sequence_checker;

    localparam int LOCK_COUNT = 3;
    localparam int ERR_W      = 4;
    localparam int ERR_MAX    = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic [2:0]       q = 3'd0;
    logic             dir, locked, step_up, step_down, err;
    logic [ERR_W-1:0] err_count;

    udc_sequence_checker #(.LOCK_COUNT(LOCK_COUNT), .ERR_W(ERR_W)) dut (
        .clk(clk), .reset(reset), .en(en), .q(q),
        .dir(dir), .locked(locked), .step_up(step_up), .step_down(step_down),
        .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: the detector is locked whenever the trailing streak of
    // same-direction steps (holds ignored, errors reset it) is long enough.
    bit m_started;
    int m_prev;
    int m_streak;
    bit m_sdir;
    bit m_dir;
    bit m_up, m_down, m_err;
    int m_errcnt;

    task automatic check_value(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit e, input int qv);
        m_up = 0; m_down = 0; m_err = 0;
        if (r) begin
            m_started = 0; m_prev = 0; m_streak = 0; m_sdir = 0; m_dir = 0; m_errcnt = 0;
        end else if (e) begin
            if (!m_started) begin
                m_started = 1;
                m_streak  = 0;
            end else begin
                int d;
                d = (qv - m_prev + 8) % 8;
                if (d == 1 || d == 7) begin
                    bit sd;
                    sd = (d == 7);
                    if (d == 1) m_up = 1; else m_down = 1;
                    if (m_streak > 0 && m_sdir == sd) m_streak++;
                    else begin m_sdir = sd; m_streak = 1; end
                    if (m_streak >= LOCK_COUNT) m_dir = m_sdir;
                end else if (d != 0) begin
                    m_err = 1;
                    m_streak = 0;
                    m_errcnt = (m_errcnt + 1 > ERR_MAX) ? ERR_MAX : m_errcnt + 1;
                end
            end
            m_prev = qv;
        end
    endtask

    task automatic drive(input bit r, input bit e, input int qv);
        reset = r;
        en    = e;
        q     = 3'(qv);
        @(posedge clk);
        #1;
        cyc++;
        model_update(r, e, qv);
        $display("cyc %0d rst=%0b en=%0b q=%0d | up=%0b dn=%0b err=%0b locked=%0b dir=%0b cnt=%0d",
                 cyc, r, e, qv, step_up, step_down, err, locked, dir, err_count);
        check_value("step_up",   int'(step_up),   int'(m_up));
        check_value("step_down", int'(step_down), int'(m_down));
        check_value("err",       int'(err),       int'(m_err));
        check_value("locked",    int'(locked),    int'(m_started && m_streak >= LOCK_COUNT));
        check_value("dir",       int'(dir),       int'(m_dir));
        check_value("err_count", int'(err_count), m_errcnt);
        check_value("pulse_onehot", int'(step_up) + int'(step_down) + int'(err) <= 1 ? 1 : 0, 1);
    endtask

    task automatic samples(input int a, input int b, input int c, input int d);
        drive(0, 1, a); drive(0, 1, b); drive(0, 1, c); drive(0, 1, d);
    endtask

    initial begin
        int qn;
        m_started = 0; m_prev = 0; m_streak = 0; m_sdir = 0; m_dir = 0;
        m_errcnt = 0; m_up = 0; m_down = 0; m_err = 0;

        // Reset state
        drive(1, 0, 0);
        drive(1, 0, 0);
        // 1: lock up
        samples(0, 1, 2, 3);
        check_value("t1_locked", int'(locked), 1);
        // 2: lock down through the 0->7 wrap
        drive(1, 0, 0);
        samples(1, 0, 7, 6);
        check_value("t2_dir", int'(dir), 1);
        // 3: holds with en gaps
        drive(1, 0, 0);
        samples(0, 1, 2, 3);
        drive(0, 0, 5); drive(0, 1, 3); drive(0, 0, 1); drive(0, 1, 3); drive(0, 0, 6);
        drive(0, 1, 4);
        check_value("t3_locked", int'(locked), 1);
        // 4: error breaks lock, relock via 7->0 wrap
        drive(1, 0, 0);
        samples(0, 1, 2, 3);
        drive(0, 1, 6);
        check_value("t4_err_count", int'(err_count), 1);
        drive(0, 1, 7); drive(0, 1, 0); drive(0, 1, 1);
        // 5: reversal keeps old dir until the new lock
        drive(1, 0, 0);
        samples(1, 2, 3, 4);
        drive(0, 1, 3);
        check_value("t5_dir_kept", int'(dir), 0);
        drive(0, 1, 2); drive(0, 1, 1);
        check_value("t5_dir_new", int'(dir), 1);
        // 6: saturating error counter, then reset beats en
        drive(1, 0, 0);
        drive(0, 1, 0);
        for (int i = 0; i < 17; i++) drive(0, 1, (i % 2 == 0) ? 4 : 0);
        check_value("t6_sat", int'(err_count), ERR_MAX);
        drive(1, 1, 5);
        drive(0, 1, 2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 3)      qn = (m_prev + 1) % 8;
            else if (r <= 6) qn = (m_prev + 7) % 8;
            else if (r == 7) qn = m_prev;
            else             qn = int'($urandom_range(0, 7));
            drive(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, qn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
